// File: rtl/calendario_param.sv
// calendario_param: BCD day/month/year calendar with true month lengths,
// Gregorian leap years, day-of-week tracking and a validated parallel load.
// One day is added per cycle with en=1 (load=0); load takes priority over en.
// All outputs are registered except leap, which is decoded from the year register.
module calendario_param #(
    parameter int              YEAR_DIGITS = 4,
    parameter logic [15:0]     YEAR_RESET  = 16'h2000,
    parameter logic [2:0]      DOW_RESET   = 3'd6,
    parameter bit              LEAP_EN     = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       load,
    input  logic [3:0]                 ld_du,
    input  logic [3:0]                 ld_dd,
    input  logic [3:0]                 ld_mu,
    input  logic [3:0]                 ld_md,
    input  logic [4*YEAR_DIGITS-1:0]   ld_year,
    input  logic [2:0]                 ld_dow,
    output logic [3:0]                 du,
    output logic [3:0]                 dd,
    output logic [3:0]                 mu,
    output logic [3:0]                 md,
    output logic [4*YEAR_DIGITS-1:0]   year,
    output logic [2:0]                 dow,
    output logic                       leap,
    output logic                       roll_m,
    output logic                       roll_y,
    output logic                       ld_err
);

    localparam int YW = 4 * YEAR_DIGITS;

    // Two-digit BCD value divisible by 4: even tens need units 0/4/8,
    // odd tens need units 2/6.
    function automatic logic div4(input logic [3:0] t, input logic [3:0] u);
        if (t[0])
            return (u == 4'd2) || (u == 4'd6);
        else
            return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
    endfunction

    // Gregorian leap test straight from BCD digits. Century years defer to
    // the upper two digits; a two-digit year of 00 is treated as leap.
    function automatic logic leap_of(input logic [YW-1:0] y);
        logic [15:0] y16;
        y16 = 16'(y);
        if (!LEAP_EN)
            return 1'b0;
        else if (y16[7:0] != 8'h00)
            return div4(y16[7:4], y16[3:0]);
        else if (YEAR_DIGITS == 4)
            return div4(y16[15:12], y16[11:8]);
        else
            return 1'b1;
    endfunction

    // Month length as a packed BCD pair {tens, units}.
    function automatic logic [7:0] month_len(input logic [7:0] m, input logic lp);
        case (m)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return lp ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    logic [3:0]    du_q, dd_q, mu_q, md_q;
    logic [3:0]    du_d, dd_d, mu_d, md_d;
    logic [YW-1:0] year_q, year_d;
    logic [2:0]    dow_q, dow_d;
    logic          roll_m_q, roll_m_d;
    logic          roll_y_q, roll_y_d;
    logic          ld_err_q, ld_err_d;

    logic [YW-1:0] year_inc;
    logic          carry;
    logic          ld_digits_ok;
    logic          ld_month_ok;
    logic          ld_day_ok;
    logic          ld_ok;
    logic [7:0]    cur_len;
    logic [7:0]    ld_len;
    logic          month_end;
    logic          year_end;

    assign leap    = leap_of(year_q);
    assign cur_len = month_len({md_q, mu_q}, leap);
    assign ld_len  = month_len({ld_md, ld_mu}, leap_of(ld_year));

    assign month_end = ({dd_q, du_q} == cur_len);
    assign year_end  = month_end && ({md_q, mu_q} == 8'h12);

    // BCD ripple increment of the year; all-9s wraps to all-0s.
    always_comb begin
        year_inc = year_q;
        carry    = 1'b1;
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            if (carry) begin
                if (year_q[4*i +: 4] == 4'd9) begin
                    year_inc[4*i +: 4] = 4'd0;
                end else begin
                    year_inc[4*i +: 4] = year_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Load validation: every digit BCD, month 01-12, day 01..length, dow 0-6.
    always_comb begin
        ld_digits_ok = (ld_du <= 4'd9) && (ld_dd <= 4'd9) &&
                       (ld_mu <= 4'd9) && (ld_md <= 4'd9);
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            if (ld_year[4*i +: 4] > 4'd9)
                ld_digits_ok = 1'b0;
        end
        ld_month_ok = ((ld_md == 4'd0) && (ld_mu != 4'd0)) ||
                      ((ld_md == 4'd1) && (ld_mu <= 4'd2));
        // BCD pairs with valid digits order the same as their numeric values.
        ld_day_ok   = ({ld_dd, ld_du} != 8'h00) && ({ld_dd, ld_du} <= ld_len);
        ld_ok       = ld_digits_ok && ld_month_ok && ld_day_ok && (ld_dow <= 3'd6);
    end

    // Next-state selection: load beats advance; pulses default low.
    always_comb begin
        du_d     = du_q;
        dd_d     = dd_q;
        mu_d     = mu_q;
        md_d     = md_q;
        year_d   = year_q;
        dow_d    = dow_q;
        roll_m_d = 1'b0;
        roll_y_d = 1'b0;
        ld_err_d = 1'b0;
        if (load) begin
            if (ld_ok) begin
                du_d   = ld_du;
                dd_d   = ld_dd;
                mu_d   = ld_mu;
                md_d   = ld_md;
                year_d = ld_year;
                dow_d  = ld_dow;
            end else begin
                ld_err_d = 1'b1;
            end
        end else if (en) begin
            dow_d = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
            if (month_end) begin
                du_d     = 4'd1;
                dd_d     = 4'd0;
                roll_m_d = 1'b1;
                if (year_end) begin
                    mu_d     = 4'd1;
                    md_d     = 4'd0;
                    year_d   = year_inc;
                    roll_y_d = 1'b1;
                end else if (mu_q == 4'd9) begin
                    mu_d = 4'd0;
                    md_d = md_q + 4'd1;
                end else begin
                    mu_d = mu_q + 4'd1;
                end
            end else if (du_q == 4'd9) begin
                du_d = 4'd0;
                dd_d = dd_q + 4'd1;
            end else begin
                du_d = du_q + 4'd1;
            end
        end
    end

    // State registers with synchronous active-low reset to 01-01-YEAR_RESET.
    always_ff @(posedge clk) begin
        if (!rst) begin
            du_q     <= 4'd1;
            dd_q     <= 4'd0;
            mu_q     <= 4'd1;
            md_q     <= 4'd0;
            year_q   <= YEAR_RESET[YW-1:0];
            dow_q    <= DOW_RESET;
            roll_m_q <= 1'b0;
            roll_y_q <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            du_q     <= du_d;
            dd_q     <= dd_d;
            mu_q     <= mu_d;
            md_q     <= md_d;
            year_q   <= year_d;
            dow_q    <= dow_d;
            roll_m_q <= roll_m_d;
            roll_y_q <= roll_y_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign du     = du_q;
    assign dd     = dd_q;
    assign mu     = mu_q;
    assign md     = md_q;
    assign year   = year_q;
    assign dow    = dow_q;
    assign roll_m = roll_m_q;
    assign roll_y = roll_y_q;
    assign ld_err = ld_err_q;

endmodule

// File: tb/tb_calendario_param.sv
// Directed bench for calendario_param: default build (4-digit year, leap on),
// a 2-digit-year build and a build with the leap rule disabled, all driven
// from the same load/enable stimulus.
module tb_calendario_param;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [3:0]  ld_du, ld_dd, ld_mu, ld_md;
    logic [15:0] ld_year;
    logic [7:0]  ld_year2;
    logic [2:0]  ld_dow;

    logic [3:0]  du, dd, mu, md;
    logic [15:0] year;
    logic [2:0]  dow;
    logic        leap, roll_m, roll_y, ld_err;

    logic [3:0]  du2, dd2, mu2, md2;
    logic [7:0]  year2;
    logic [2:0]  dow2;
    logic        leap2, roll_m2, roll_y2, ld_err2;

    logic [3:0]  du3, dd3, mu3, md3;
    logic [15:0] year3;
    logic [2:0]  dow3;
    logic        leap3, roll_m3, roll_y3, ld_err3;

    int checks;
    int failures;

    assign ld_year2 = ld_year[7:0];

    calendario_param dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .ld_du(ld_du), .ld_dd(ld_dd), .ld_mu(ld_mu), .ld_md(ld_md),
        .ld_year(ld_year), .ld_dow(ld_dow),
        .du(du), .dd(dd), .mu(mu), .md(md), .year(year), .dow(dow),
        .leap(leap), .roll_m(roll_m), .roll_y(roll_y), .ld_err(ld_err)
    );

    calendario_param #(.YEAR_DIGITS(2), .YEAR_RESET(16'h2000)) dut2 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .ld_du(ld_du), .ld_dd(ld_dd), .ld_mu(ld_mu), .ld_md(ld_md),
        .ld_year(ld_year2), .ld_dow(ld_dow),
        .du(du2), .dd(dd2), .mu(mu2), .md(md2), .year(year2), .dow(dow2),
        .leap(leap2), .roll_m(roll_m2), .roll_y(roll_y2), .ld_err(ld_err2)
    );

    calendario_param #(.LEAP_EN(1'b0)) dut3 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .ld_du(ld_du), .ld_dd(ld_dd), .ld_mu(ld_mu), .ld_md(ld_md),
        .ld_year(ld_year), .ld_dow(ld_dow),
        .du(du3), .dd(dd3), .mu(mu3), .md(md3), .year(year3), .dow(dow3),
        .leap(leap3), .roll_m(roll_m3), .roll_y(roll_y3), .ld_err(ld_err3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Date packed as DDMMYYYY in BCD for readable expected values.
    function automatic logic [31:0] date1();
        return {dd, du, md, mu, year};
    endfunction

    function automatic logic [31:0] date3();
        return {dd3, du3, md3, mu3, year3};
    endfunction

    function automatic logic [31:0] date2();
        return {8'h00, dd2, du2, md2, mu2, year2};
    endfunction

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic drive_load(input logic [7:0] day, input logic [7:0] mon,
                              input logic [15:0] yr, input logic [2:0] dw,
                              input logic with_en);
        ld_dd   = day[7:4];
        ld_du   = day[3:0];
        ld_md   = mon[7:4];
        ld_mu   = mon[3:0];
        ld_year = yr;
        ld_dow  = dw;
        load    = 1'b1;
        en      = with_en;
        step();
        load    = 1'b0;
        en      = 1'b0;
    endtask

    task automatic advance(input int n);
        en = 1'b1;
        for (int i = 0; i < n; i++) step();
        en = 1'b0;
    endtask

    task automatic bad_load(input string tag, input logic [7:0] day, input logic [7:0] mon,
                            input logic [15:0] yr, input logic [2:0] dw);
        drive_load(day, mon, yr, dw, 1'b0);
        check({tag, "_err"}, {31'd0, ld_err}, 32'd1);
        check({tag, "_date"}, date1(), 32'h15032023);
        check({tag, "_dow"}, {29'd0, dow}, 32'd3);
        step();
        check({tag, "_err_clr"}, {31'd0, ld_err}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; en = 1'b0; load = 1'b0;
        ld_du = 4'd0; ld_dd = 4'd0; ld_mu = 4'd0; ld_md = 4'd0;
        ld_year = 16'h0000; ld_dow = 3'd0;

        // Reset held two cycles with en high.
        rst = 1'b0; en = 1'b1;
        step(); step();
        rst = 1'b1; en = 1'b0;
        check("rst_date", date1(), 32'h01012000);
        check("rst_dow", {29'd0, dow}, 32'd6);
        check("rst_pulses", {29'd0, roll_m, roll_y, ld_err}, 32'd0);
        check("rst_leap", {31'd0, leap}, 32'd1);
        advance(1);
        check("first_adv", date1(), 32'h02012000);
        check("first_adv_dow", {29'd0, dow}, 32'd0);
        check("first_adv_rollm", {31'd0, roll_m}, 32'd0);

        // Month ends.
        drive_load(8'h31, 8'h01, 16'h2023, 3'd2, 1'b0);
        check("ld_jan31", date1(), 32'h31012023);
        check("ld_jan31_err", {31'd0, ld_err}, 32'd0);
        advance(1);
        check("jan_end", date1(), 32'h01022023);
        check("jan_end_rolls", {30'd0, roll_m, roll_y}, 32'b10);
        check("jan_end_dow", {29'd0, dow}, 32'd3);
        step();
        check("rollm_one_cycle", {31'd0, roll_m}, 32'd0);
        drive_load(8'h30, 8'h04, 16'h2023, 3'd0, 1'b0);
        advance(1);
        check("apr_end", date1(), 32'h01052023);
        drive_load(8'h09, 8'h05, 16'h2023, 3'd0, 1'b0);
        advance(1);
        check("day_09_10", date1(), 32'h10052023);

        // Leap years.
        drive_load(8'h28, 8'h02, 16'h2023, 3'd0, 1'b0);
        check("leap_2023", {31'd0, leap}, 32'd0);
        advance(1);
        check("feb_2023", date1(), 32'h01032023);
        drive_load(8'h28, 8'h02, 16'h2024, 3'd0, 1'b0);
        check("leap_2024", {31'd0, leap}, 32'd1);
        advance(1);
        check("feb_2024_29", date1(), 32'h29022024);
        check("feb_2024_29_rollm", {31'd0, roll_m}, 32'd0);
        check("noleap_2024", date3(), 32'h01032024);
        check("noleap_leapflag", {31'd0, leap3}, 32'd0);
        advance(1);
        check("feb_2024_end", date1(), 32'h01032024);
        drive_load(8'h28, 8'h02, 16'h1900, 3'd0, 1'b0);
        check("leap_1900", {31'd0, leap}, 32'd0);
        advance(1);
        check("feb_1900", date1(), 32'h01031900);
        drive_load(8'h28, 8'h02, 16'h2000, 3'd0, 1'b0);
        advance(1);
        check("feb_2000", date1(), 32'h29022000);

        // Year wrap, four- and two-digit builds.
        drive_load(8'h31, 8'h12, 16'h9999, 3'd3, 1'b0);
        advance(1);
        check("wrap_9999", date1(), 32'h01010000);
        check("wrap_rolls", {30'd0, roll_m, roll_y}, 32'b11);
        check("wrap_dow", {29'd0, dow}, 32'd4);
        check("wrap_99", date2(), 32'h00010100);
        check("wrap_99_rolly", {31'd0, roll_y2}, 32'd1);
        step();
        check("wrap_rolls_clr", {30'd0, roll_m, roll_y}, 32'b00);
        drive_load(8'h30, 8'h09, 16'h2023, 3'd0, 1'b0);
        advance(1);
        check("sep_end", date1(), 32'h01102023);

        // Load validation: baseline 15-03-2023 dow 3, then rejected loads.
        drive_load(8'h15, 8'h03, 16'h2023, 3'd3, 1'b0);
        check("baseline", date1(), 32'h15032023);
        bad_load("rej_apr31", 8'h31, 8'h04, 16'h2023, 3'd1);
        bad_load("rej_feb29", 8'h29, 8'h02, 16'h2023, 3'd1);
        bad_load("rej_mon13", 8'h10, 8'h13, 16'h2023, 3'd1);
        bad_load("rej_day00", 8'h00, 8'h05, 16'h2023, 3'd1);
        bad_load("rej_digitA", 8'h0A, 8'h05, 16'h2023, 3'd1);
        bad_load("rej_yeardig", 8'h10, 8'h05, 16'h20B3, 3'd1);
        bad_load("rej_dow7", 8'h10, 8'h05, 16'h2023, 3'd7);
        drive_load(8'h29, 8'h02, 16'h2024, 3'd4, 1'b0);
        check("acc_feb29", date1(), 32'h29022024);
        check("acc_feb29_err", {31'd0, ld_err}, 32'd0);
        check("acc_feb29_dow", {29'd0, dow}, 32'd4);

        // Priority: load with en, and reset with load.
        drive_load(8'h10, 8'h10, 16'h2010, 3'd2, 1'b1);
        check("load_over_en", date1(), 32'h10102010);
        check("load_over_en_dow", {29'd0, dow}, 32'd2);
        drive_load(8'h31, 8'h12, 16'h2023, 3'd2, 1'b0);
        en = 1'b1; load = 1'b1; rst = 1'b0;
        step();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        check("rst_over_load", date1(), 32'h01012000);
        check("rst_over_load_pulses", {29'd0, roll_m, roll_y, ld_err}, 32'd0);

        // 50-day burst from 01-01-2000.
        advance(50);
        check("burst_date", date1(), 32'h20022000);
        check("burst_dow", {29'd0, dow}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calendario_param.md
# calendario_param

BCD day/month/year calendar counter with true month lengths, Gregorian leap years, day-of-week tracking, and a validated parallel load. It advances one day per qualified `en` cycle. It is the parametrised successor of the team's fixed 31-day/12-month day-month counter and drives display and date-stamp logic directly with BCD digits.

## Interface
- `YEAR_DIGITS`, 4: number of BCD year digits; legal values 2 or 4.
- `YEAR_RESET`, 16'h2000: BCD reset year; the low `4*YEAR_DIGITS` bits are used.
- `DOW_RESET`, 6: reset day of week (0 = Sunday … 6 = Saturday).
- `LEAP_EN`, 1: 1 = Gregorian leap rule; 0 = February always has 28 days.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `en` in 1: advance one day.
- `load` in 1: load the `ld_*` values.
- `ld_du`, `ld_dd`, `ld_mu`, `ld_md` in 4 each: load day units/tens and month units/tens.
- `ld_year` in 4*YEAR_DIGITS: BCD load year.
- `ld_dow` in 3: load day of week.
- `du`, `dd`, `mu`, `md` out 4 each: current day and month digits, BCD.
- `year` out 4*YEAR_DIGITS: current year, BCD.
- `dow` out 3: current day of week.
- `leap` out 1: current year is a leap year.
- `roll_m` out 1: one-cycle pulse, date just entered day 01 of a month.
- `roll_y` out 1: one-cycle pulse, date just entered 01-01.
- `ld_err` out 1: one-cycle pulse, last load was rejected.

## Operation
- Reset (`rst`=0 at an edge):
  - Date is 01-01-`YEAR_RESET`: `du`=1, `dd`=0, `mu`=1, `md`=0.
  - `dow`=`DOW_RESET`.
  - `roll_m`, `roll_y`, `ld_err` = 0.
  - Reset overrides `load` and `en`.
- Priority: `rst` > `load` > `en`. When `load` is high, `en` is ignored that cycle and no day advance occurs.
- Month length:
  - 31 days for months 01, 03, 05, 07, 08, 10, 12.
  - 30 days for months 04, 06, 09, 11.
  - February: 29 if `leap`, else 28.
- Leap rule (`LEAP_EN`=1), computed combinationally from the BCD year with no binary conversion:
  - If the last two digits are not 00: leap when the two-digit value is divisible by 4. That is, tens digit even with units in {0,4,8}, or tens digit odd with units in {2,6}.
  - If the last two digits are 00 and `YEAR_DIGITS`=4: leap when the upper two digits satisfy the same divisible-by-4 test.
  - If the last two digits are 00 and `YEAR_DIGITS`=2: always leap.
  - With `LEAP_EN`=0, `leap` is held at 0.
- Advance (`en`=1, `load`=0):
  - Day below month length: increment the day in BCD (09→10, 19→20, 29→30).
  - Day equals month length: day becomes 01, month increments in BCD (09→10), and `roll_m` pulses.
  - Month 12 rollover: month becomes 01, year increments as a BCD ripple, and `roll_y` pulses together with `roll_m`.
  - Year all-9s wraps to all-0s.
  - `dow` increments 6→0 on every advance.
- Load (`load`=1):
  - Accepted only if every digit is ≤9, the month is 01–12, and the day is 01 through the month length of the loaded month and year (leap computed from `ld_year`), and `ld_dow` ≤6.
  - Accepted: all state takes the `ld_*` values, `ld_err`=0, and no roll pulses.
  - Rejected: all state is unchanged and `ld_err` pulses.
- Pulses (`roll_m`, `roll_y`, `ld_err`) are registered and cleared on every edge where their cause is absent.

## Timing
- All outputs are registered. A change sampled at edge N is visible after edge N.
- Roll pulses are high in the same cycle in which the new date is first visible, for exactly one cycle per advance.
- `leap` is combinational from the registered `year`, so it is valid in the same cycle as `year`.
- Back-to-back `en` advances one day per cycle with no dead cycles.
- Reset mid-operation: the next edge yields the reset state regardless of `en`/`load`. Pulses pending from the previous cycle are cleared.
- No handshake: `en` and `load` are level-sampled every edge.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `en`=1, then release → 01-01-2000, `dow`=6, all pulses 0. One `en` → 02-01-2000, `dow`=0.
- Month ends: load 31-01-2023, `en` → 01-02-2023 with `roll_m`=1, `roll_y`=0. Load 30-04-2023, `en` → 01-05-2023.
- Leap years:
  - 28-02-2023, `en` → 01-03-2023.
  - 28-02-2024 → 29-02-2024, then → 01-03-2024.
  - 28-02-1900 → 01-03-1900.
  - 28-02-2000 → 29-02-2000.
  - With `LEAP_EN`=0: 28-02-2024 → 01-03-2024.
- Year wrap: load 31-12-9999, `en` → 01-01-0000 with `roll_m`=`roll_y`=1 for one cycle. With `YEAR_DIGITS`=2: 31-12-99 → 01-01-00.
- Load validation, each rejected with `ld_err`=1 for one cycle and state unchanged: 31-04-2023; 29-02-2023; month 13; day 00; digit 4'hA; `ld_dow`=7. Then 29-02-2024 is accepted with `ld_err`=0.
- Priority: `load`=1 and `en`=1 together → loaded date, not advanced. `rst`=0 with `load`=1 → reset date. A 50-cycle `en` burst from 01-01-2000 → 20-02-2000, `dow`=0.
